// File: rtl/m68k_bus_decoder.sv
// 68000-style address decoder with a programmable region table,
// per-region wait states and a bus-error watchdog for unmapped accesses.
module m68k_bus_decoder #(
    parameter  int N_REGIONS = 24,
    parameter  int ADDR_W    = 24,
    parameter  int TIMEOUT   = 64,
    localparam int IDX_W     = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ADDR_W-1:0]    cpu_a,
    input  logic                 cpu_as_n,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [ADDR_W-1:0]    cfg_base,
    input  logic [4:0]           cfg_shift,
    input  logic [3:0]           cfg_wait,
    input  logic                 cfg_en,
    output logic [N_REGIONS-1:0] cs,
    output logic [IDX_W-1:0]     hit_idx,
    output logic                 dtack_n,
    output logic                 berr_n,
    output logic                 multi_hit
);

    localparam int CNT_MAX = (TIMEOUT - 1 > 15) ? TIMEOUT - 1 : 15;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_MISS,
        S_ERR
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               armed;

    logic               rg_en    [N_REGIONS];
    logic [ADDR_W-1:0]  rg_base  [N_REGIONS];
    logic [4:0]         rg_shift [N_REGIONS];
    logic [3:0]         rg_wait  [N_REGIONS];

    logic [N_REGIONS-1:0] match;
    logic                 hit;
    logic                 multi;
    logic [IDX_W-1:0]     win;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < N_REGIONS; r++) begin
                rg_en[r]    <= 1'b0;
                rg_base[r]  <= '0;
                rg_shift[r] <= '0;
                rg_wait[r]  <= '0;
            end
        end else if (cfg_we && int'(cfg_idx) < N_REGIONS) begin
            rg_en[cfg_idx]    <= cfg_en;
            rg_base[cfg_idx]  <= cfg_base;
            rg_shift[cfg_idx] <= cfg_shift;
            rg_wait[cfg_idx]  <= cfg_wait;
        end
    end

    // Shifts past the address width zero both sides, so such a region
    // matches every address.
    always_comb begin
        match = '0;
        hit   = 1'b0;
        multi = 1'b0;
        win   = '0;
        for (int r = 0; r < N_REGIONS; r++) begin
            match[r] = rg_en[r] &&
                ((cpu_a >> rg_shift[r]) == (rg_base[r] >> rg_shift[r]));
            if (match[r]) begin
                if (hit) begin
                    multi = 1'b1;
                end else begin
                    hit = 1'b1;
                    win = IDX_W'(r);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            armed     <= 1'b0;
            cs        <= '0;
            hit_idx   <= '0;
            dtack_n   <= 1'b1;
            berr_n    <= 1'b1;
            multi_hit <= 1'b0;
        end else begin
            // A strobe already low when reset lifts must rise before decode.
            if (cpu_as_n) armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (armed && !cpu_as_n) begin
                        if (hit) begin
                            cs      <= N_REGIONS'(1) << win;
                            hit_idx <= win;
                            cnt     <= CNT_W'(rg_wait[win]);
                            state   <= S_WAIT;
                            if (multi) multi_hit <= 1'b1;
                        end else begin
                            cnt   <= CNT_W'(TIMEOUT - 1);
                            state <= S_MISS;
                        end
                    end
                end
                S_WAIT: begin
                    if (cpu_as_n) begin
                        cs    <= '0;
                        state <= S_IDLE;
                    end else if (cnt == '0) begin
                        dtack_n <= 1'b0;
                        state   <= S_ACK;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_ACK: begin
                    if (cpu_as_n) begin
                        cs      <= '0;
                        dtack_n <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                S_MISS: begin
                    if (cpu_as_n) begin
                        state <= S_IDLE;
                    end else if (cnt == '0) begin
                        berr_n <= 1'b0;
                        state  <= S_ERR;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_ERR: begin
                    if (cpu_as_n) begin
                        berr_n <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_bus_decoder.sv
// Scoreboard bench for m68k_bus_decoder: directed scenarios plus
// randomized table writes and accesses against a region-table model.
module tb_m68k_bus_decoder;

    localparam int N  = 24;
    localparam int AW = 24;
    localparam int TO = 64;
    localparam int IW = 5;

    localparam int K_SEL = 0;
    localparam int K_ACK = 1;
    localparam int K_ERR = 2;
    localparam int K_REL = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] cpu_a = '0;
    logic          cpu_as_n = 1'b1;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [AW-1:0] cfg_base = '0;
    logic [4:0]    cfg_shift = '0;
    logic [3:0]    cfg_wait = '0;
    logic          cfg_en = 1'b0;
    logic [N-1:0]  cs;
    logic [IW-1:0] hit_idx;
    logic          dtack_n;
    logic          berr_n;
    logic          multi_hit;

    m68k_bus_decoder #(
        .N_REGIONS(N),
        .ADDR_W(AW),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cpu_a(cpu_a),
        .cpu_as_n(cpu_as_n),
        .cfg_we(cfg_we),
        .cfg_idx(cfg_idx),
        .cfg_base(cfg_base),
        .cfg_shift(cfg_shift),
        .cfg_wait(cfg_wait),
        .cfg_en(cfg_en),
        .cs(cs),
        .hit_idx(hit_idx),
        .dtack_n(dtack_n),
        .berr_n(berr_n),
        .multi_hit(multi_hit)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] cs;
        int          idx;
        bit          multi;
    } exp_t;

    exp_t sb[$];

    logic [AW-1:0] m_base  [32];
    int            m_shift [32];
    int            m_wait  [32];
    bit            m_en    [32];
    bit            m_multi;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic string kname(input int k);
        case (k)
            K_SEL:   return "sel";
            K_ACK:   return "ack";
            K_ERR:   return "err";
            default: return "rel";
        endcase
    endfunction

    function automatic void clear_model();
        for (int r = 0; r < 32; r++) begin
            m_base[r]  = '0;
            m_shift[r] = 0;
            m_wait[r]  = 0;
            m_en[r]    = 1'b0;
        end
        m_multi = 1'b0;
    endfunction

    // Region hits when every address bit above the ignored low bits agrees.
    function automatic void lookup(input logic [AW-1:0] a,
                                   output int win, output int nh);
        win = -1;
        nh  = 0;
        for (int r = 0; r < N; r++) begin
            if (m_en[r] && (m_shift[r] >= AW ||
                ((a ^ m_base[r]) >> m_shift[r]) == '0)) begin
                nh++;
                if (win < 0) win = r;
            end
        end
    endfunction

    function automatic void push(input int k, input int c, input int w);
        exp_t x;
        x.kind  = k;
        x.cyc   = c;
        x.cs    = (w >= 0) ? (32'd1 << w) : 32'd0;
        x.idx   = w;
        x.multi = m_multi;
        sb.push_back(x);
    endfunction

    // Strobe sampled low at edges e .. e+len-1, high at e+len.
    function automatic void issue(input logic [AW-1:0] a, input int len,
                                  input int e);
        int win, nh;
        lookup(a, win, nh);
        if (nh > 0) begin
            if (nh > 1) m_multi = 1'b1;
            push(K_SEL, e, win);
            if (len >= 2 + m_wait[win])
                push(K_ACK, e + 1 + m_wait[win], win);
            push(K_REL, e + len, win);
        end else if (len >= TO + 1) begin
            push(K_ERR, e + TO, -1);
            push(K_REL, e + len, -1);
        end
    endfunction

    task automatic cfg_write(input int idx, input logic [AW-1:0] b,
                             input int sh, input int w, input bit en);
        cfg_we    = 1'b1;
        cfg_idx   = IW'(idx);
        cfg_base  = b;
        cfg_shift = 5'(sh);
        cfg_wait  = 4'(w);
        cfg_en    = en;
        @(negedge clk);
        cfg_we = 1'b0;
        if (idx < N) begin
            m_base[idx]  = b;
            m_shift[idx] = sh;
            m_wait[idx]  = w;
            m_en[idx]    = en;
        end
    endtask

    task automatic bus_cycle(input logic [AW-1:0] a, input int len);
        cpu_a    = a;
        cpu_as_n = 1'b0;
        issue(a, len, cyc + 1);
        repeat (len) @(negedge clk);
        cpu_as_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic handle(input int k);
        exp_t e;
        string n;
        n = kname(k);
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_%s: event at cycle %0d, expected none",
                     n, cyc);
            return;
        end
        e = sb.pop_front();
        check({n, "_kind"}, k, e.kind);
        check({n, "_cycle"}, cyc, e.cyc);
        if (k == K_SEL) begin
            check("sel_cs", 64'(cs), 64'(e.cs));
            check("sel_hit_idx", 64'(hit_idx), 64'(e.idx));
        end
        if (k == K_SEL || k == K_REL)
            check({n, "_multi_hit"}, 64'(multi_hit), 64'(e.multi));
    endtask

    bit           mon_en = 1'b0;
    logic [N-1:0] p_cs = '0;
    logic         p_dt = 1'b1;
    logic         p_be = 1'b1;

    always @(negedge clk) begin
        check("cs_onehot", 64'($countones(cs) <= 1), 64'd1);
        check("dtack_berr_excl", 64'(dtack_n | berr_n), 64'd1);
        if (mon_en && reset_n) begin
            if (cs != '0 && p_cs == '0) handle(K_SEL);
            if (!dtack_n && p_dt) handle(K_ACK);
            if (!berr_n && p_be) handle(K_ERR);
            if (cs == '0 && dtack_n && berr_n &&
                (p_cs != '0 || !p_dt || !p_be)) handle(K_REL);
        end
        p_cs = cs;
        p_dt = dtack_n;
        p_be = berr_n;
    end

    initial begin
        int len, r, win, nh;
        logic [AW-1:0] a, mask;
        clear_model();
        repeat (3) @(negedge clk);
        check("rst_cs", 64'(cs), 64'd0);
        check("rst_hit_idx", 64'(hit_idx), 64'd0);
        check("rst_dtack_n", 64'(dtack_n), 64'd1);
        check("rst_berr_n", 64'(berr_n), 64'd1);
        check("rst_multi_hit", 64'(multi_hit), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        cfg_write(0, 24'h000000, 19, 0, 1'b1);
        bus_cycle(24'h07FFFE, 4);

        cfg_write(5, 24'h400008, 3, 3, 1'b1);
        bus_cycle(24'h40000C, 6);
        bus_cycle(24'h400010, TO + 2);

        cfg_write(2, 24'h140000, 16, 1, 1'b1);
        cfg_write(7, 24'h100000, 20, 2, 1'b1);
        bus_cycle(24'h140000, 5);
        bus_cycle(24'h07FFFE, 3);
        bus_cycle(24'h40000C, 2);

        cfg_write(9, 24'h800000, 8, 7, 1'b1);
        bus_cycle(24'h800055, 3);
        bus_cycle(24'h07FFFE, 3);

        fork
            bus_cycle(24'h800055, 12);
            begin
                repeat (3) @(negedge clk);
                cfg_write(9, 24'h800000, 8, 7, 1'b0);
            end
        join
        bus_cycle(24'h800055, TO + 2);

        cfg_write(31, 24'hA00000, 8, 0, 1'b1);
        bus_cycle(24'hA00012, 5);

        cfg_write(12, 24'h123456, 24, 2, 1'b1);
        bus_cycle(24'hFFFFF0, 6);
        cfg_write(12, 24'h123456, 24, 2, 1'b0);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                cfg_write(int'($urandom_range(0, 31)), AW'($urandom),
                          int'($urandom_range(4, 26)),
                          int'($urandom_range(0, 15)),
                          $urandom_range(0, 3) != 0);
            end else begin
                r = int'($urandom_range(0, N - 1));
                mask = (m_shift[r] >= AW) ? '1 :
                       ((AW'(1) << m_shift[r]) - AW'(1));
                if ($urandom_range(0, 3) == 0) a = AW'($urandom);
                else a = m_base[r] ^ (AW'($urandom) & mask);
                lookup(a, win, nh);
                if (nh > 0)
                    len = int'($urandom_range(1, m_wait[win] + 4));
                else if ($urandom_range(0, 5) == 0)
                    len = TO + 1 + int'($urandom_range(0, 1));
                else
                    len = int'($urandom_range(1, 6));
                bus_cycle(a, len);
            end
        end

        cfg_write(0, 24'h000000, 19, 0, 1'b1);
        cpu_a    = 24'h07FFFE;
        cpu_as_n = 1'b0;
        issue(24'h07FFFE, 100, cyc + 1);
        repeat (3) @(negedge clk);
        check("pre_reset_dtack_n", 64'(dtack_n), 64'd0);
        mon_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_cs", 64'(cs), 64'd0);
        check("async_rst_dtack_n", 64'(dtack_n), 64'd1);
        check("async_rst_berr_n", 64'(berr_n), 64'd1);
        check("async_rst_multi_hit", 64'(multi_hit), 64'd0);
        sb.delete();
        clear_model();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        repeat (5) @(negedge clk);
        check("held_strobe_cs", 64'(cs), 64'd0);
        check("held_strobe_berr_n", 64'(berr_n), 64'd1);
        cpu_as_n = 1'b1;
        @(negedge clk);
        bus_cycle(24'h07FFFE, TO + 2);
        bus_cycle(24'h140000, 3);
        bus_cycle(24'h800055, TO + 1);

        repeat (4) @(negedge clk);
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
